// File: rtl/gerenciador_bolas.sv
// Projectile pool: up to N_BOLAS balls fired from a spawn point, moved on a frame tick,
// retired at the screen edge or on a target hit, with a hit counter and a persistent record.
module gerenciador_bolas #(
  parameter int N_BOLAS  = 4,
  parameter int LARGURA  = 640,
  parameter int ALTURA   = 480,
  parameter int RAIO     = 4,
  parameter int VEL      = 2,
  parameter int DIV_TICK = 833333,
  parameter int DIRECAO  = 0
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  input  logic                   pausa,
  input  logic                   reiniciarJogo,
  input  logic                   disparo,
  input  logic [9:0]             origemX,
  input  logic [9:0]             origemY,
  input  logic [9:0]             alvoX,
  input  logic [9:0]             alvoY,
  input  logic [9:0]             alvoLargura,
  input  logic [9:0]             alvoAltura,
  output logic [N_BOLAS-1:0]     ativos,
  output logic [10*N_BOLAS-1:0]  x_flat,
  output logic [10*N_BOLAS-1:0]  y_flat,
  output logic [9:0]             raio,
  output logic                   atingiu,
  output logic                   disparoNegado,
  output logic [7:0]             acertos,
  output logic [7:0]             recorde
);

  localparam int CNT_W = (DIV_TICK > 1) ? $clog2(DIV_TICK) : 1;
  localparam int IDX_W = (N_BOLAS > 1) ? $clog2(N_BOLAS) : 1;

  if (N_BOLAS < 1 || N_BOLAS > 16 || VEL < 1 || VEL > 15 || LARGURA < 1 || ALTURA < 1 ||
      DIV_TICK < 1) begin : g_bad_params
    $error("gerenciador_bolas: parameter out of range");
  end

  logic [9:0]       pos_x [N_BOLAS];
  logic [9:0]       pos_y [N_BOLAS];
  logic [CNT_W-1:0] divisor;

  logic               tick;
  logic [N_BOLAS-1:0] hit;
  logic [N_BOLAS-1:0] sai;
  logic [4:0]         n_hits;
  logic               livre_ok;
  logic [IDX_W-1:0]   livre_idx;
  logic [8:0]         soma;
  logic [7:0]         acertos_prox;
  logic               in_x;
  logic               in_y;
  logic               borda;

  assign raio = 10'(RAIO);

  always_comb begin
    // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
    tick         = 1'b0;
    hit          = '0;
    sai          = '0;
    n_hits       = '0;
    livre_ok     = 1'b0;
    livre_idx    = '0;
    in_x         = 1'b0;
    in_y         = 1'b0;
    borda        = 1'b0;

    tick = !pausa && (divisor == CNT_W'(DIV_TICK - 1));

    // Rectangle test uses 11 bits so alvo + size never wraps back into the screen.
    for (int i = 0; i < N_BOLAS; i++) begin
      in_x = ({1'b0, pos_x[i]} >= {1'b0, alvoX}) &&
             ({1'b0, pos_x[i]} <  ({1'b0, alvoX} + {1'b0, alvoLargura}));
      in_y = ({1'b0, pos_y[i]} >= {1'b0, alvoY}) &&
             ({1'b0, pos_y[i]} <  ({1'b0, alvoY} + {1'b0, alvoAltura}));
      if (DIRECAO == 0) borda = pos_y[i] < 10'(VEL);
      else              borda = ({1'b0, pos_y[i]} + 11'(VEL)) > 11'(ALTURA - 1);
      hit[i] = tick && ativos[i] && in_x && in_y;
      sai[i] = tick && ativos[i] && !(in_x && in_y) && borda;
      n_hits = n_hits + 5'(hit[i]);
    end

    // Descending scan leaves the lowest free index as the winner.
    for (int i = N_BOLAS - 1; i >= 0; i--) begin
      if (!ativos[i]) begin
        livre_ok  = 1'b1;
        livre_idx = IDX_W'(i);
      end
    end

    soma         = {1'b0, acertos} + 9'(n_hits);
    acertos_prox = (soma > 9'd255) ? 8'd255 : soma[7:0];
  end

  always_comb begin
    x_flat = '0;
    y_flat = '0;
    for (int i = 0; i < N_BOLAS; i++) begin
      x_flat[10*i +: 10] = pos_x[i];
      y_flat[10*i +: 10] = pos_y[i];
    end
  end

  always_ff @(posedge CLOCK_50) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (reset) begin
      ativos        <= '0;
      divisor       <= '0;
      atingiu       <= 1'b0;
      disparoNegado <= 1'b0;
      acertos       <= '0;
      recorde       <= '0;
      // NOTE: the slot coordinate arrays are small flops, not RAM, so they are reset with the rest.
      for (int i = 0; i < N_BOLAS; i++) begin
        pos_x[i] <= '0;
        pos_y[i] <= '0;
      end
    end else begin
      atingiu       <= 1'b0;
      disparoNegado <= 1'b0;
      if (acertos > recorde) recorde <= acertos;

      if (reiniciarJogo) begin
        ativos  <= '0;
        divisor <= '0;
        acertos <= '0;
      end else if (!pausa) begin
        divisor <= tick ? '0 : divisor + 1'b1;

        for (int i = 0; i < N_BOLAS; i++) begin
          if (hit[i] || sai[i]) begin
            ativos[i] <= 1'b0;
          end else if (tick && ativos[i]) begin
            if (DIRECAO == 0) pos_y[i] <= pos_y[i] - 10'(VEL);
            else              pos_y[i] <= pos_y[i] + 10'(VEL);
          end
        end

        // The chosen slot was inactive at the start of the cycle, so the tick loop never touches it.
        if (disparo) begin
          if (livre_ok) begin
            ativos[livre_idx] <= 1'b1;
            pos_x[livre_idx]  <= origemX;
            pos_y[livre_idx]  <= origemY;
          end else begin
            disparoNegado <= 1'b1;
          end
        end

        if (n_hits != 5'd0) begin
          atingiu <= 1'b1;
          acertos <= acertos_prox;
        end
      end
    end
  end

endmodule

// File: tb/tb_gerenciador_bolas.sv
// Scoreboard bench for gerenciador_bolas: a slot-level reference model predicts the
// registered outputs of every cycle; a monitor compares them half a cycle after the edge.
module tb_gerenciador_bolas;

  localparam int N   = 4;
  localparam int DIV = 4;
  localparam int VEL = 2;
  localparam int ALT = 480;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset, pausa, reiniciarJogo, disparo;
  logic [9:0]      origemX, origemY, alvoX, alvoY, alvoLargura, alvoAltura;
  logic [N-1:0]    ativos;
  logic [10*N-1:0] x_flat, y_flat;
  logic [9:0]      raio;
  logic            atingiu, disparoNegado;
  logic [7:0]      acertos, recorde;

  gerenciador_bolas #(
    .N_BOLAS(N), .LARGURA(640), .ALTURA(ALT), .RAIO(4), .VEL(VEL), .DIV_TICK(DIV), .DIRECAO(0)
  ) dut (
    .CLOCK_50(clk), .reset(reset), .pausa(pausa), .reiniciarJogo(reiniciarJogo),
    .disparo(disparo), .origemX(origemX), .origemY(origemY), .alvoX(alvoX), .alvoY(alvoY),
    .alvoLargura(alvoLargura), .alvoAltura(alvoAltura), .ativos(ativos), .x_flat(x_flat),
    .y_flat(y_flat), .raio(raio), .atingiu(atingiu), .disparoNegado(disparoNegado),
    .acertos(acertos), .recorde(recorde)
  );

  typedef struct {
    logic [N-1:0]    ativos;
    logic [10*N-1:0] xs;
    logic [10*N-1:0] ys;
    logic            atingiu;
    logic            negado;
    logic [7:0]      acertos;
    logic [7:0]      recorde;
  } snap_t;

  snap_t sb[$];
  int checks   = 0;
  int failures = 0;

  // Reference model: plain per-ball integers.
  bit m_act[N];
  int m_x[N];
  int m_y[N];
  int m_div = 0, m_acertos = 0, m_recorde = 0;
  bit m_atingiu = 0, m_negado = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic bit in_rect(input int px, input int py);
    int ax, ay, aw, ah;
    ax = int'(alvoX);
    ay = int'(alvoY);
    aw = int'(alvoLargura);
    ah = int'(alvoAltura);
    return (px >= ax) && (px < ax + aw) && (py >= ay) && (py < ay + ah);
  endfunction

  task automatic model_step(input bit r, input bit p, input bit ri, input bit d,
                            input int ox, input int oy);
    bit was[N];
    bit tk;
    int hits;
    int found;
    m_atingiu = 0;
    m_negado  = 0;
    if (r) begin
      for (int i = 0; i < N; i++) begin
        m_act[i] = 0; m_x[i] = 0; m_y[i] = 0;
      end
      m_div = 0; m_acertos = 0; m_recorde = 0;
      return;
    end
    was = m_act;
    if (m_acertos > m_recorde) m_recorde = m_acertos;
    if (ri) begin
      for (int i = 0; i < N; i++) m_act[i] = 0;
      m_div = 0;
      m_acertos = 0;
    end else if (!p) begin
      tk = (m_div == DIV - 1);
      m_div = tk ? 0 : m_div + 1;
      hits = 0;
      if (tk) begin
        for (int i = 0; i < N; i++) begin
          if (was[i]) begin
            if (in_rect(m_x[i], m_y[i])) begin
              m_act[i] = 0;
              hits++;
            end else if (m_y[i] < VEL) begin
              m_act[i] = 0;
            end else begin
              m_y[i] = m_y[i] - VEL;
            end
          end
        end
      end
      if (d) begin
        found = -1;
        for (int i = 0; i < N; i++) if (!was[i] && found < 0) found = i;
        if (found >= 0) begin
          m_act[found] = 1;
          m_x[found] = ox;
          m_y[found] = oy;
        end else begin
          m_negado = 1;
        end
      end
      if (hits > 0) begin
        m_atingiu = 1;
        m_acertos = (m_acertos + hits > 255) ? 255 : m_acertos + hits;
      end
    end
  endtask

  // Drive one cycle of inputs, push the predicted post-edge outputs, advance past the edge.
  task automatic drive(input bit r, input bit p, input bit ri, input bit d,
                       input int ox, input int oy);
    snap_t e;
    reset = r; pausa = p; reiniciarJogo = ri; disparo = d;
    origemX = 10'(ox); origemY = 10'(oy);
    model_step(r, p, ri, d, ox, oy);
    for (int i = 0; i < N; i++) begin
      e.ativos[i]     = m_act[i];
      e.xs[10*i +: 10] = 10'(m_x[i]);
      e.ys[10*i +: 10] = 10'(m_y[i]);
    end
    e.atingiu = m_atingiu;
    e.negado  = m_negado;
    e.acertos = 8'(m_acertos);
    e.recorde = 8'(m_recorde);
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic set_alvo(input int ax, input int ay, input int aw, input int ah);
    alvoX = 10'(ax); alvoY = 10'(ay); alvoLargura = 10'(aw); alvoAltura = 10'(ah);
  endtask

  // Monitor: an entry present at an edge was issued before that edge; compare at the falling edge.
  snap_t mon_e;
  initial begin
    forever begin
      @(posedge clk);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        @(negedge clk);
        check("ativos",        64'(ativos),        64'(mon_e.ativos));
        check("x_flat",        64'(x_flat),        64'(mon_e.xs));
        check("y_flat",        64'(y_flat),        64'(mon_e.ys));
        check("atingiu",       64'(atingiu),       64'(mon_e.atingiu));
        check("disparoNegado", 64'(disparoNegado), 64'(mon_e.negado));
        check("acertos",       64'(acertos),       64'(mon_e.acertos));
        check("recorde",       64'(recorde),       64'(mon_e.recorde));
        check("raio",          64'(raio),          64'd4);
      end
    end
  end

  initial begin
    bit p;
    set_alvo(600, 470, 5, 5);
    #1;
    // Reset, single ball flying up from y=10 to the edge without a hit.
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 100, 10);
    idle(30);

    // Five consecutive fire pulses: the fifth is refused.
    for (int k = 0; k < 5; k++) drive(0, 0, 0, 1, 200, 300);
    idle(6);

    // Double hit in one tick, then a third hit, restart keeps the record, reset clears it.
    drive(0, 0, 1, 0, 0, 0);
    set_alvo(40, 90, 30, 20);
    drive(0, 0, 0, 1, 50, 100);
    drive(0, 0, 0, 1, 60, 100);
    idle(6);
    drive(0, 0, 0, 1, 50, 100);
    idle(6);
    drive(0, 0, 1, 0, 0, 0);
    idle(3);
    drive(1, 0, 0, 0, 0, 0);
    idle(2);

    // Pause while balls fly: fire is ignored, divider and positions hold.
    set_alvo(600, 470, 5, 5);
    drive(0, 0, 0, 1, 300, 400);
    drive(0, 0, 0, 1, 310, 400);
    idle(1);
    for (int k = 0; k < 20; k++) drive(0, 1, 0, (k % 3) == 0, 320, 200);
    idle(10);

    // Full pool fired at in the same cycle a tick retires slot 2; the retry next cycle gets slot 2.
    drive(0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 100, 200);
    drive(0, 0, 0, 1, 110, 200);
    drive(0, 0, 0, 1, 120, 3);
    drive(0, 0, 0, 1, 130, 200);
    idle(3);
    drive(0, 0, 0, 1, 140, 250);
    drive(0, 0, 0, 1, 150, 250);
    idle(4);

    // Saturation of the hit counter with a target covering the whole screen.
    drive(0, 0, 1, 0, 0, 0);
    set_alvo(0, 0, 1023, 1023);
    for (int k = 0; k < 320; k++) drive(0, 0, 0, 1, 100, 100);
    idle(8);
    drive(0, 0, 1, 0, 0, 0);
    idle(2);

    // Randomized traffic.
    drive(1, 0, 0, 0, 0, 0);
    p = 0;
    for (int k = 0; k < 2500; k++) begin
      if (k % 50 == 0) begin
        if ($urandom_range(0, 3) == 0) set_alvo(0, 0, 1023, 1023);
        else set_alvo($urandom_range(0, 1023), $urandom_range(0, 1023),
                      $urandom_range(0, 300), $urandom_range(0, 300));
      end
      if ($urandom_range(0, 9) == 0) p = !p;
      drive($urandom_range(0, 299) == 0, p, $urandom_range(0, 99) == 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 1023), $urandom_range(0, 479));
    end
    idle(2);

    repeat (2) @(negedge clk);
    check("scoreboard_drain", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gerenciador_bolas.md
# gerenciador_bolas

Parametrised projectile pool for the shooter game: manages up to N_BOLAS simultaneous balls fired from a nave (or inimigo), moves them vertically on a frame-rate tick, retires them at the screen edge or on hitting a target rectangle, and keeps a hit counter plus a record that survives game restarts. It replaces the single-ball `bola` instance in `projeto`. Its coordinate outputs feed the `tela` renderer.

## Interface
- N_BOLAS, 4: number of ball slots (1..16)
- LARGURA, 640: active screen width in pixels
- ALTURA, 480: active screen height in pixels
- RAIO, 4: ball radius reported on `raio`
- VEL, 2: pixels moved per tick (1..15)
- DIV_TICK, 833333: CLOCK_50 cycles per movement tick (60 Hz)
- DIRECAO, 0: 0 = balls move up (nave), 1 = balls move down (inimigo)

Ports:
- CLOCK_50  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; clears everything including `recorde`
- pausa  in  1  level; freezes tick divider, movement and firing
- reiniciarJogo  in  1  one-cycle pulse; clears slots, divider and `acertos`, keeps `recorde`
- disparo  in  1  one-cycle fire request
- origemX, origemY  in  10 each  spawn position (ball centre)
- alvoX, alvoY  in  10 each  target rectangle top-left
- alvoLargura, alvoAltura  in  10 each  target rectangle size
- ativos  out  N_BOLAS  slot i active
- x_flat, y_flat  out  10*N_BOLAS each  slot i centre at bits [10i+9:10i]
- raio  out  10  constant RAIO
- atingiu  out  1  one-cycle pulse, at least one hit this tick
- disparoNegado  out  1  one-cycle pulse, fire refused (no free slot)
- acertos  out  8  hit count, saturates at 255
- recorde  out  8  maximum `acertos` since reset

## Operation
- Reset values: ativos=0, all x/y=0, atingiu=0, disparoNegado=0, acertos=0, recorde=0, divider=0. `raio` is constant.
- Tick: divider counts 0..DIV_TICK-1 while pausa=0; internal `tick` is high in the cycle the divider equals DIV_TICK-1, after which it wraps to 0. With pausa=1 the divider holds its value.
- Fire (pausa=0, disparo=1): allocate the lowest-index slot that is inactive at the start of the cycle; next cycle ativos[i]=1, x=origemX, y=origemY. If every slot is busy, no state changes and disparoNegado pulses. With pausa=1, disparo is ignored with no pulse.
- Per active slot on tick, in strict priority:
  1. Hit: centre in [alvoX, alvoX+alvoLargura) × [alvoY, alvoY+alvoAltura), evaluated on the pre-move position, 11-bit compare with no wrap. Effect: slot deactivates.
  2. Exit: DIRECAO=0 and y < VEL, or DIRECAO=1 and y+VEL > ALTURA-1. Effect: slot deactivates with no hit.
  3. Otherwise: y -= VEL (DIRECAO=0) or y += VEL (DIRECAO=1); x unchanged.
- Hits in one tick: k = popcount of hits. acertos = min(acertos+k, 255). atingiu pulses once regardless of k.
- Deactivated slots keep their last x/y values; consumers must gate on ativos.
- Fire and tick in the same cycle: the tick processes only slots active at the start of the cycle. The new slot is not moved. A slot freed by this tick cannot be allocated until the next cycle.
- recorde: if acertos > recorde, recorde ← acertos (one cycle behind acertos).
- reiniciarJogo has priority over fire and tick in its cycle. reset has priority over everything. Either one issued mid-flight clears all slots in one cycle.

## Timing
- Every output is registered.
- disparo → ativos/x/y valid: 1 cycle. disparo → disparoNegado: 1 cycle.
- tick cycle → updated positions, atingiu, acertos: 1 cycle. acertos → recorde: +1 cycle.
- Fire throughput: 1 per cycle until the pool is full.
- Flight time, DIRECAO=0, no hit: ceil((y0-VEL+1)/VEL) movement ticks, plus 1 retiring tick.

## Test plan
Bench parameters unless stated: N_BOLAS=4, DIV_TICK=4, VEL=2, DIRECAO=0.
- Reset, then fire with origem=(100,10): next cycle ativos=0001, x=100, y=10. y reads 8, 6, 4, 2, 0 on successive ticks; on the next tick ativos=0000, atingiu stays 0.
- Five disparo pulses on consecutive cycles: ativos fills 0001 → 1111. The 5th pulse gives disparoNegado=1 and ativos unchanged.
- Two balls at (50,100) and (60,100); target (40,90,30,20): at the next tick both slots clear, atingiu is high for exactly 1 cycle, acertos=2, recorde=2 one cycle later.
- pausa=1 for 20 cycles while balls fly: y and the divider are frozen; disparo yields no slot and no disparoNegado. Release pausa: motion resumes from the saved divider value.
- acertos=3, recorde=3, then reiniciarJogo: ativos=0, acertos=0, recorde=3. Then reset: recorde=0.
- Fire into a full pool in the same cycle a tick retires slot 2: fire is refused (disparoNegado=1). Firing again next cycle allocates slot 2.
